// File: rtl/score_arbiter_pkg.sv
// Shared constants and types for the score arbiter and score_counter.
package score_pkg;

  localparam int MAX_SCORE_DEF          = 9999;
  localparam int MAX_SCORE_INCREASE_DEF = 99;
  localparam int PTS_W_DEF              = $clog2(MAX_SCORE_INCREASE_DEF);
  localparam int SCORE_W_DEF            = $clog2(MAX_SCORE_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/score_arbiter_if.sv
// Hit-request / score bus between mole logic, the arbiter and score_counter.
interface score_arbiter_if
  import score_pkg::*;
#(
  parameter int N_MOLES = 8,
  parameter int PTS_W   = PTS_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int ID_W    = $clog2(N_MOLES)
);
  logic                       game_en;
  logic [N_MOLES-1:0]         hit_req;
  logic [N_MOLES*PTS_W-1:0]   hit_pts;
  logic [SCORE_W-1:0]         score_count;
  logic [PTS_W-1:0]           score_increase;
  logic                       award_valid;
  logic [ID_W-1:0]            award_id;
  logic [N_MOLES-1:0]         hit_drop;
  logic                       busy;

  modport master (
    output game_en, hit_req, hit_pts, score_count,
    input  score_increase, award_valid, award_id, hit_drop, busy
  );

  modport slave (
    input  game_en, hit_req, hit_pts, score_count,
    output score_increase, award_valid, award_id, hit_drop, busy
  );
endinterface

// File: rtl/score_arbiter_rr_picker.sv
// Round-robin picker: lowest pending index at or after the pointer, wrapping.
module rr_picker #(
  parameter int N_MOLES = 8,
  parameter int ID_W    = $clog2(N_MOLES)
) (
  input  logic [N_MOLES-1:0] pending_i,
  input  logic [ID_W-1:0]    rr_i,
  output logic               grant_valid_o,
  output logic [ID_W-1:0]    grant_id_o
);

  int idx;

  // Scan from the farthest offset down so the nearest pending index wins last.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    idx           = 0;
    for (int k = N_MOLES - 1; k >= 0; k--) begin
      idx = int'(rr_i) + k;
      if (idx >= N_MOLES) idx = idx - N_MOLES;
      if (pending_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_id_o    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// Arbitrates per-mole hit awards onto the single score_counter input,
// clamping at MAX_SCORE and separating awards with a zero gap.
//
// state | meaning
// IDLE  | pick next pending hit; emit clamped award or drop if saturated
// EMIT  | award on score_increase this cycle; counter adds it at next edge
// GAP   | score_increase held at zero so equal awards register as changes
module score_arbiter
  import score_pkg::*;
#(
  parameter int N_MOLES            = 8,
  parameter int MAX_SCORE          = MAX_SCORE_DEF,
  parameter int MAX_SCORE_INCREASE = MAX_SCORE_INCREASE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  score_arbiter_if.slave bus
);

  localparam int PTS_W   = $clog2(MAX_SCORE_INCREASE);
  localparam int SCORE_W = $clog2(MAX_SCORE);
  localparam int ID_W    = $clog2(N_MOLES);

  arb_state_t         state_q, state_d;
  logic [N_MOLES-1:0] pending_q, pending_d;
  logic [N_MOLES-1:0] hit_drop_q, hit_drop_d;
  logic [PTS_W-1:0]   pend_pts_q [N_MOLES];
  logic [PTS_W-1:0]   pend_pts_d [N_MOLES];
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    award_id_q, award_id_d;
  logic [PTS_W-1:0]   score_inc_q, score_inc_d;
  logic               award_valid_q, award_valid_d;
  logic               busy_q;

  logic               grant_valid, grant_fire;
  logic [ID_W-1:0]    grant_id;
  logic [N_MOLES-1:0] grant_oh;
  logic [PTS_W-1:0]   grant_pts, inc;
  logic [SCORE_W-1:0] headroom, pts_ext;

  rr_picker #(
    .N_MOLES (N_MOLES),
    .ID_W    (ID_W)
  ) u_picker (
    .pending_i     (pending_q),
    .rr_i          (rr_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Clamp is min(pts, MAX_SCORE - score); result never exceeds pts, so it fits PTS_W.
  assign grant_pts = pend_pts_q[grant_id];
  assign headroom  = SCORE_W'(MAX_SCORE) - bus.score_count;
  assign pts_ext   = {{(SCORE_W - PTS_W){1'b0}}, grant_pts};
  assign inc       = (pts_ext <= headroom) ? grant_pts : headroom[PTS_W-1:0];
  assign grant_oh  = grant_fire ? (N_MOLES'(1) << grant_id) : '0;

  always_comb begin
    state_d       = state_q;
    score_inc_d   = '0;
    award_valid_d = 1'b0;
    award_id_d    = award_id_q;
    rr_d          = rr_q;
    grant_fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.game_en && grant_valid) begin
          grant_fire = 1'b1;
          rr_d = (grant_id == ID_W'(N_MOLES - 1)) ? '0 : grant_id + ID_W'(1);
          if (inc != '0) begin
            score_inc_d   = inc;
            award_valid_d = 1'b1;
            award_id_d    = grant_id;
            state_d       = EMIT;
          end
        end
      end
      EMIT:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A request arriving while its mole is being granted replaces the old entry.
  always_comb begin
    pending_d  = pending_q;
    pend_pts_d = pend_pts_q;
    hit_drop_d = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (!bus.game_en) begin
        pending_d[i]  = 1'b0;
        hit_drop_d[i] = bus.hit_req[i];
      end else begin
        if (grant_oh[i]) pending_d[i] = 1'b0;
        if (bus.hit_req[i]) begin
          if (!pending_q[i] || grant_oh[i]) begin
            pending_d[i]  = 1'b1;
            pend_pts_d[i] = bus.hit_pts[i*PTS_W +: PTS_W];
          end else begin
            hit_drop_d[i] = 1'b1;
          end
        end
      end
    end
    if (grant_fire && (inc == '0)) hit_drop_d[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      for (int i = 0; i < N_MOLES; i++) pend_pts_q[i] <= '0;
      rr_q          <= '0;
      score_inc_q   <= '0;
      award_valid_q <= 1'b0;
      award_id_q    <= '0;
      hit_drop_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      pend_pts_q    <= pend_pts_d;
      rr_q          <= rr_d;
      score_inc_q   <= score_inc_d;
      award_valid_q <= award_valid_d;
      award_id_q    <= award_id_d;
      hit_drop_q    <= hit_drop_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  assign bus.score_increase = score_inc_q;
  assign bus.award_valid    = award_valid_q;
  assign bus.award_id       = award_id_q;
  assign bus.hit_drop       = hit_drop_q;
  assign bus.busy           = busy_q;

endmodule

// File: doc/score_arbiter.md
Name: score_arbiter

Overview:
- Shares the single score_counter datapath between N_MOLES mole-hit requesters.
- Buffers one pending hit per mole and grants pending hits round-robin.
- Clamps each award so the score never exceeds MAX_SCORE.
- score_counter only adds when score_increase changes, so every award is emitted as a one-cycle value followed by a one-cycle zero gap. Back-to-back equal awards are therefore never lost.
- Sits between the mole/hit-detect logic and score_counter; drives score_counter.score_increase and reads score_counter.score_count.

Parameters:
- N_MOLES, 8, number of requesters (moles); ≥2.
- MAX_SCORE, 9999, score ceiling; must match score_counter.
- MAX_SCORE_INCREASE, 99, largest single award; must match score_counter.
- PTS_W, $clog2(MAX_SCORE_INCREASE) (derived), award width.
- SCORE_W, $clog2(MAX_SCORE) (derived), score width.
- ID_W, $clog2(N_MOLES) (derived), mole index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- game_en  in  1  high while a round is running; low flushes and blocks all requests.
- hit_req  in  N_MOLES  one-cycle hit pulse per mole.
- hit_pts  in  N_MOLES*PTS_W  points per mole, flattened, mole i at [i*PTS_W +: PTS_W]; sampled with hit_req[i].
- score_count  in  SCORE_W  current score from score_counter.
- score_increase  out  PTS_W  registered, to score_counter.
- award_valid  out  1  pulse in the cycle score_increase carries a nonzero award.
- award_id  out  ID_W  mole granted; valid with award_valid.
- hit_drop  out  N_MOLES  pulse per mole whose request was lost (overflow or game_en low).
- busy  out  1  high in EMIT or GAP.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, pending and pend_pts cleared, rr pointer=0, score_increase=0, award_valid=0, award_id=0, hit_drop=0, busy=0. Reset mid-award abandons it; nothing further is emitted.
- Capture, per mole i, each cycle:
  - hit_req[i] && game_en && (!pending[i] || grant_this_cycle[i]): set pending[i] and latch pts.
  - hit_req[i] while pending[i] and not being granted: keep the old pts; hit_drop[i] pulses the next cycle.
  - hit_req[i] with game_en==0: hit_drop[i] pulses.
- game_en falling: all pending entries are cleared silently, with no hit_drop. An EMIT/GAP already in flight completes.
- FSM states are IDLE, EMIT, GAP:
  - IDLE: if any pending, grant the lowest index at or after rr (wrapping). Clear that entry and compute inc = min(pts, MAX_SCORE - score_count).
    - inc != 0: register score_increase=inc, award_valid=1, award_id=i, go to EMIT.
    - inc == 0 (score saturated): consume the entry with no emit; hit_drop[i] pulses; stay IDLE.
    - In both cases rr = i+1 mod N_MOLES.
  - EMIT (1 cycle): score_increase=0, award_valid=0, go to GAP. score_counter adds inc at this edge.
  - GAP (1 cycle): score_increase stays 0 (score_counter records 0 as prev), go to IDLE. score_count is up to date by the next IDLE decision.
- Throughput and latency:
  - Throughput is one award per 3 cycles.
  - Latency is hit_req edge -> score_increase valid = 2 edges when idle.
- Arithmetic:
  - The clamp subtraction is done at SCORE_W bits.
  - pts is zero-extended to SCORE_W before the compare.
  - The result fits in PTS_W because it is ≤ pts.
- hit_pts value 0: accepted and granted, inc=0, handled as the saturated case (dropped, pulse).
- A grant and a new request for the same mole in the same cycle: the new request is accepted.
- Outputs are glitch-free registers; no combinational path from inputs to outputs.

Decomposition:
- Package score_pkg holds:
  - MAX_SCORE and MAX_SCORE_INCREASE defaults.
  - The state enum arb_state_t {IDLE, EMIT, GAP}.
  - PTS_W/SCORE_W helper localparams, shared with score_counter.
- Sub-module rr_picker is combinational: pending vector + rr pointer -> grant_valid, grant_id. It is instantiated once.

Test Plan:
- Reset: rst=0 for 2 cycles with hit_req=8'hFF -> score_increase=0, busy=0, no hit_drop. After release, no award until a new request.
- Single hit, mole 3, pts=10, score 0 -> score_increase 10 for exactly 1 cycle with award_id=3, then 0; score_count=10; the sequence takes 3 cycles.
- Equal back-to-back: mole 2 pts=5 twice, 3 cycles apart -> emitted sequence 5,0,0,5,0; score_count=10 (zero gap proven).
- Simultaneous hits from moles 0, 5 and 7 (pts 1, 2, 3), rr=6 -> grant order 7, 0, 5; score_count=6; no drops.
- Overflow and saturation:
  - Mole 1 hits twice while pending (pts 4 then 9) -> award 4 only; hit_drop[1] pulses once.
  - Score 9990 + pts 20 -> inc 9, score 9999.
  - A further hit of 50 -> no emit; hit_drop pulses.
- game_en drop mid-stream: 3 pending, game_en goes 0 during EMIT -> the current award completes, the other 2 are cleared, and later hit_req raise hit_drop.
